// File: rtl/loader_write_scheduler.sv
// Loader write scheduler: DEPTH-entry write FIFO drained one entry per CE_DIV-cycle memory slot.
// Optional feature macro WRITE_MERGE_EN: same-address rewrites of the newest queued entry are merged.
module loader_write_scheduler #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int CE_DIV     = 4,
  parameter int SLOT_PHASE = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_write,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [$clog2(CE_DIV)-1:0]   phase,
  output logic                        slot,
  output logic                        mem_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow
);

  localparam int PH_W  = $clog2(CE_DIV);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PH_W-1:0]   r_phase;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic [ADDR_W-1:0] r_addr_q [DEPTH];
  logic [DATA_W-1:0] r_data_q [DEPTH];
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_overflow;

  logic              w_slot;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic [PTR_W-1:0]  w_newest;
  logic              w_merge_hit;
  logic              w_merge;
  logic              w_push;
  logic              w_drop;

  // FIFO control decode: pop, push, merge and drop decisions for this cycle
  always_comb begin
    w_slot   = (r_phase == PH_W'(SLOT_PHASE));
    w_empty  = (r_level == {LVL_W{1'b0}});
    w_full   = (r_level == LVL_W'(DEPTH));
    w_pop    = w_slot && !w_empty;
    w_newest = r_wptr - PTR_W'(1);
`ifdef WRITE_MERGE_EN
    // The newest entry is the head only when one entry is queued; merging into it while it pops would be lost.
    w_merge_hit = !w_empty && (r_addr_q[w_newest] == in_addr) &&
                  !(w_pop && (r_level == LVL_W'(1)));
`else
    w_merge_hit = 1'b0;
`endif
    w_merge  = in_write && w_merge_hit;
    w_push   = in_write && !w_merge_hit && (!w_full || w_pop);
    w_drop   = in_write && !w_merge_hit && w_full && !w_pop;
  end

  // Free-running slot divider, untouched by flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= {PH_W{1'b0}};
    end else if (r_phase == PH_W'(CE_DIV - 1)) begin
      r_phase <= {PH_W{1'b0}};
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  // FIFO storage: new entries at the write pointer, merged data into the newest entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_q[i] <= {ADDR_W{1'b0}};
        r_data_q[i] <= {DATA_W{1'b0}};
      end
    end else if (flush) begin
      r_addr_q <= r_addr_q;
      r_data_q <= r_data_q;
    end else if (w_push) begin
      r_addr_q[r_wptr] <= in_addr;
      r_data_q[r_wptr] <= in_data;
    end else if (w_merge) begin
      r_data_q[w_newest] <= in_data;
    end else begin
      r_addr_q <= r_addr_q;
      r_data_q <= r_data_q;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= {PTR_W{1'b0}};
      r_rptr     <= {PTR_W{1'b0}};
      r_level    <= {LVL_W{1'b0}};
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wptr     <= {PTR_W{1'b0}};
      r_rptr     <= {PTR_W{1'b0}};
      r_level    <= {LVL_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  // Memory request: only changes on slot edges so each request spans a full divider period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_write <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_data  <= {DATA_W{1'b0}};
    end else if (flush) begin
      r_mem_write <= 1'b0;
      r_mem_addr  <= r_mem_addr;
      r_mem_data  <= r_mem_data;
    end else if (w_pop) begin
      r_mem_write <= 1'b1;
      r_mem_addr  <= r_addr_q[r_rptr];
      r_mem_data  <= r_data_q[r_rptr];
    end else if (w_slot) begin
      r_mem_write <= 1'b0;
      r_mem_addr  <= r_mem_addr;
      r_mem_data  <= r_mem_data;
    end else begin
      r_mem_write <= r_mem_write;
      r_mem_addr  <= r_mem_addr;
      r_mem_data  <= r_mem_data;
    end
  end

  assign in_ready  = !w_full || w_pop || w_merge_hit;
  assign phase     = r_phase;
  assign slot      = w_slot;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_loader_write_scheduler.sv
// Bench for loader_write_scheduler: hand-computed vector table, corner sequences, and a queue-based reference model under random traffic.
module tb_loader_write_scheduler;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam int CE_DIV = 4;
  localparam int SLOT_PHASE = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_write = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [1:0]        phase;
  logic              slot;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [2:0]        level;
  logic              overflow;

  int total = 0;
  int bad = 0;

  loader_write_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CE_DIV(CE_DIV), .SLOT_PHASE(SLOT_PHASE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_write(in_write),
    .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready), .phase(phase),
    .slot(slot), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Vector table: inputs for one cycle and the expected state after its rising edge
  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              fl;
    logic              rdy;
    logic              mw;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] md;
    int                lvl;
    logic              ovf;
  } vec_t;
  vec_t tq[$];

  task automatic add(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic fl, input logic rdy, input logic mw,
                     input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                     input int lvl, input logic ovf, input int n);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.fl = fl; v.rdy = rdy;
    v.mw = mw; v.ma = ma; v.md = md; v.lvl = lvl; v.ovf = ovf;
    for (int k = 0; k < n; k++) tq.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic fl);
    in_write = wr; in_addr = a; in_data = d; flush = fl;
    @(posedge clk);
    #1;
    in_write = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_write = 1'b0; flush = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model: queue of pending writes and a phase counter
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t mq[$];
  int   m_ph;
  logic m_mw;
  logic [ADDR_W-1:0] m_ma;
  logic [DATA_W-1:0] m_md;
  logic m_ovf;

  task automatic model_reset();
    mq.delete();
    m_ph = 0; m_mw = 1'b0; m_ma = '0; m_md = '0; m_ovf = 1'b0;
  endtask

  task automatic rtick(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic fl);
    bit   s, pop, mh, acc;
    ent_t e;
    s   = (m_ph == SLOT_PHASE);
    pop = s && (mq.size() > 0);
    mh  = 1'b0;
`ifdef WRITE_MERGE_EN
    mh = (mq.size() > 0) && (mq[$].a == a) && !(pop && mq.size() == 1);
`endif
    in_write = wr; in_addr = a; in_data = d; flush = fl;
    #1;
    chk("r_ready", in_ready, (mq.size() < DEPTH) || pop || mh);
    chk("r_slot", slot, s);
    chk("r_phase", phase, m_ph);
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_mw = 1'b0;
      m_ovf = 1'b0;
    end else begin
      acc = wr && !mh && ((mq.size() < DEPTH) || pop);
      if (pop) begin
        e = mq.pop_front();
        m_mw = 1'b1; m_ma = e.a; m_md = e.d;
      end else if (s) begin
        m_mw = 1'b0;
      end
      if (wr && mh) mq[mq.size()-1].d = d;
      if (acc) begin
        e.a = a; e.d = d;
        mq.push_back(e);
      end else if (wr && !mh) begin
        m_ovf = 1'b1;
      end
    end
    m_ph = (m_ph + 1) % CE_DIV;
    #1;
    chk("r_mem_write", mem_write, m_mw);
    chk("r_mem_addr", mem_addr, m_ma);
    chk("r_mem_data", mem_data, m_md);
    chk("r_level", level, mq.size());
    chk("r_overflow", overflow, m_ovf);
    @(negedge clk);
  endtask

  initial begin
    // Single write, burst with overflow, push at full slot, flush with pending entries
    add(1, 22'h100, 8'hA5, 0, 1, 0, 22'h0,   8'h00, 1, 0, 1);
    add(0, 22'h0,   8'h00, 0, 1, 0, 22'h0,   8'h00, 1, 0, 2);
    add(0, 22'h0,   8'h00, 0, 1, 1, 22'h100, 8'hA5, 0, 0, 4);
    add(1, 22'h201, 8'h01, 0, 1, 0, 22'h100, 8'hA5, 1, 0, 1);
    add(1, 22'h202, 8'h02, 0, 1, 0, 22'h100, 8'hA5, 2, 0, 1);
    add(1, 22'h203, 8'h03, 0, 1, 0, 22'h100, 8'hA5, 3, 0, 1);
    add(1, 22'h204, 8'h04, 0, 1, 0, 22'h100, 8'hA5, 4, 0, 1);
    add(1, 22'h205, 8'h05, 0, 1, 1, 22'h201, 8'h01, 4, 0, 1);
    add(1, 22'h206, 8'h06, 0, 0, 1, 22'h201, 8'h01, 4, 1, 1);
    add(0, 22'h0,   8'h00, 0, 0, 1, 22'h201, 8'h01, 4, 1, 2);
    add(0, 22'h0,   8'h00, 0, 1, 1, 22'h202, 8'h02, 3, 1, 4);
    add(0, 22'h0,   8'h00, 0, 1, 1, 22'h203, 8'h03, 2, 1, 4);
    add(0, 22'h0,   8'h00, 0, 1, 1, 22'h204, 8'h04, 1, 1, 4);
    add(0, 22'h0,   8'h00, 0, 1, 1, 22'h205, 8'h05, 0, 1, 4);
    add(0, 22'h0,   8'h00, 0, 1, 0, 22'h205, 8'h05, 0, 1, 1);
    add(1, 22'h301, 8'h11, 0, 1, 0, 22'h205, 8'h05, 1, 1, 1);
    add(1, 22'h302, 8'h12, 0, 1, 0, 22'h205, 8'h05, 2, 1, 1);
    add(1, 22'h303, 8'h13, 0, 1, 0, 22'h205, 8'h05, 3, 1, 1);
    add(1, 22'h304, 8'h14, 0, 1, 1, 22'h301, 8'h11, 3, 1, 1);
    add(1, 22'h305, 8'h15, 1, 1, 0, 22'h301, 8'h11, 0, 0, 1);
    add(0, 22'h0,   8'h00, 0, 1, 0, 22'h301, 8'h11, 0, 0, 1);

    do_reset();
    chk("reset_phase", phase, 0);
    chk("reset_mem_write", mem_write, 0);
    chk("reset_level", level, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_mem_addr", mem_addr, 0);

    for (int i = 0; i < tq.size(); i++) begin
      in_write = tq[i].wr; in_addr = tq[i].a; in_data = tq[i].d; flush = tq[i].fl;
      #1;
      chk($sformatf("t%0d_ready", i), in_ready, tq[i].rdy);
      chk($sformatf("t%0d_phase", i), phase, i % CE_DIV);
      chk($sformatf("t%0d_slot", i), slot, (i % CE_DIV) == SLOT_PHASE);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_mem_write", i), mem_write, tq[i].mw);
      chk($sformatf("t%0d_mem_addr", i), mem_addr, tq[i].ma);
      chk($sformatf("t%0d_mem_data", i), mem_data, tq[i].md);
      chk($sformatf("t%0d_level", i), level, tq[i].lvl);
      chk($sformatf("t%0d_overflow", i), overflow, tq[i].ovf);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an in-flight request
    drive(1, 22'h400, 8'h21, 0);
    drive(0, 22'h0, 8'h00, 0);
    chk("t5_pre_mem_write", mem_write, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_phase", phase, 0);
    chk("t5_mem_write", mem_write, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_mem_data", mem_data, 0);
    chk("t5_level", level, 0);
    chk("t5_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("t5_rel_phase0", phase, 0);
    @(posedge clk);
    #1;
    chk("t5_rel_phase1", phase, 1);
    chk("t5_rel_mem_write", mem_write, 0);
    @(negedge clk);

    // Two writes to the same address before a slot
    drive(1, 22'h0000FF, 8'h11, 0);
    chk("t6_level_a", level, 1);
    drive(1, 22'h0000FF, 8'h22, 0);
`ifdef WRITE_MERGE_EN
    chk("t6_level_b", level, 1);
    drive(0, 22'h0, 8'h00, 0);
    chk("t6_mem_write", mem_write, 1);
    chk("t6_mem_data", mem_data, 8'h22);
    chk("t6_level_c", level, 0);
    repeat (4) drive(0, 22'h0, 8'h00, 0);
    chk("t6_mem_write_end", mem_write, 0);
`else
    chk("t6_level_b", level, 2);
    drive(0, 22'h0, 8'h00, 0);
    chk("t6_mem_write", mem_write, 1);
    chk("t6_mem_data", mem_data, 8'h11);
    chk("t6_level_c", level, 1);
    repeat (4) drive(0, 22'h0, 8'h00, 0);
    chk("t6_mem_write_2", mem_write, 1);
    chk("t6_mem_data_2", mem_data, 8'h22);
`endif

    // Random traffic against the queue model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic              wr, fl;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      wr = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 199) == 0);
      a  = 22'h3000 + 22'($urandom_range(0, 3));
      d  = 8'($urandom);
      rtick(wr, a, d, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
